sail_stdout_drain: RTL and testbench

- Downstream stage of the Sail print/print_endline library modules.
- Consumes the characters appended to sail_stdout as a byte stream and line-buffers them in an internal FIFO.
- Releases them byte-by-byte over a valid/ready handshake to a console sink: UART transmitter, simulation monitor or trace port.
- Guarantees whole lines reach the sink unless the buffer fills or an explicit flush is requested.

---
 rtl/sail_stdout_drain_if.sv | 47 ++++
 rtl/sail_stdout_drain.sv | 234 +++++++++++++++++++++++
 tb/tb_sail_stdout_drain.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sail_stdout_drain_if.sv
// sail_stdout_drain_if: character-in / byte-out bundle for the Sail stdout drain.
// The master side is the print producer together with the console sink.
// The slave side is the drain itself.
// Status outputs (level, emitted count, idle) travel with the handshakes.
interface sail_stdout_drain_if #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 32
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             in_char_valid;
   logic [7:0]       in_char;
   logic             out_char_ready;
   logic             in_flush;
   logic             out_byte_valid;
   logic [7:0]       out_byte;
   logic             in_byte_ready;
   logic [LW-1:0]    out_level;
   logic [CNT_W-1:0] out_emitted;
   logic             out_idle;

   modport master (
      output in_char_valid,
      output in_char,
      output in_flush,
      output in_byte_ready,
      input  out_char_ready,
      input  out_byte_valid,
      input  out_byte,
      input  out_level,
      input  out_emitted,
      input  out_idle
   );

   modport slave (
      input  in_char_valid,
      input  in_char,
      input  in_flush,
      input  in_byte_ready,
      output out_char_ready,
      output out_byte_valid,
      output out_byte,
      output out_level,
      output out_emitted,
      output out_idle
   );
endinterface

// File: rtl/sail_stdout_drain.sv
// sail_stdout_drain: line-buffers the Sail stdout character stream in a FIFO.
// It releases whole lines, one byte per cycle, to a console sink over valid/ready.
// A full buffer or an in_flush pulse forces release without a newline.
// DEPTH must be a power of two and at least 4, so that the pointers wrap naturally.
// Optional build macro SAIL_STDOUT_CRLF_EN: each 0x0A leaves the drain as 0x0D then 0x0A.
// The macro is undefined by default, and bytes then pass through unchanged.
module sail_stdout_drain #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 32
) (
   input logic                in_clk,
   input logic                in_reset,
   sail_stdout_drain_if.slave bus
);
   localparam int            PW         = $clog2(DEPTH);
   localparam int            LW         = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE    = LW'(1);
   localparam logic [LW-1:0] LVL_TWO    = LW'(2);
   localparam logic [7:0]    LF         = 8'h0A;
`ifdef SAIL_STDOUT_CRLF_EN
   localparam logic [7:0]    CR         = 8'h0D;
`endif

   typedef enum logic {
      ST_IDLE,
      ST_DRAIN
   } state_t;

   logic [7:0]       mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [LW-1:0]    level;
   logic [LW-1:0]    level_next;
   logic [LW-1:0]    pend_nl;
   logic [LW-1:0]    pend_nl_next;
   logic             flush_req;
   logic             flush_req_next;
   state_t           state;
   state_t           state_next;

   logic             byte_valid_q;
   logic [7:0]       byte_q;
   logic [CNT_W-1:0] emitted_q;

   logic             char_ready;
   logic             enq;
   logic             enq_nl;
   logic             hs;
   logic             pop;
   logic             pop_nl;
   logic [7:0]       head;
   logic [7:0]       head_after;

   logic             load_en;
   logic             load_valid;
   logic [7:0]       load_byte;

`ifdef SAIL_STDOUT_CRLF_EN
   logic             cr_sent;
   logic             showing_cr;
`endif

   assign head       = mem[rd_ptr];
   assign head_after = mem[rd_ptr + PW'(1)];
   assign hs         = byte_valid_q && bus.in_byte_ready;

`ifdef SAIL_STDOUT_CRLF_EN
   // A presented newline with cr_sent clear is really the inserted CR, so it does not pop.
   assign showing_cr = byte_valid_q && (head == LF) && !cr_sent;
   assign pop        = hs && !showing_cr;
`else
   assign pop        = hs;
`endif

   // When the FIFO is full, a slot opens in the same cycle as a dequeue. The path is from in_byte_ready only.
   assign char_ready = (level < FULL_LEVEL) || ((level == FULL_LEVEL) && pop);
   assign enq        = bus.in_char_valid && char_ready;
   assign enq_nl     = enq && (bus.in_char == LF);
   assign pop_nl     = pop && (head == LF);

   // Occupancy and buffered-newline bookkeeping. Simultaneous push and pop cancel.
   always_comb begin
      level_next   = level;
      pend_nl_next = pend_nl;
      case ({enq, pop})
         2'b10:   level_next = level + LVL_ONE;
         2'b01:   level_next = level - LVL_ONE;
         default: level_next = level;
      endcase
      case ({enq_nl, pop_nl})
         2'b10:   pend_nl_next = pend_nl + LVL_ONE;
         2'b01:   pend_nl_next = pend_nl - LVL_ONE;
         default: pend_nl_next = pend_nl;
      endcase
   end

   // A flush request sticks until the buffer runs empty. A flush of an empty buffer is ignored.
   always_comb begin
      flush_req_next = flush_req;
      if (bus.in_flush && (level != '0)) begin
         flush_req_next = 1'b1;
      end
      if (level_next == '0) begin
         flush_req_next = 1'b0;
      end
   end

   // Next-state logic. Drain on a buffered newline, a full buffer or a flush. Return to idle at a line end or when empty.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if ((pend_nl != '0) || (level == FULL_LEVEL) || flush_req ||
                (bus.in_flush && (level != '0))) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && ((level_next == '0) ||
                        (pop_nl && (pend_nl_next == '0) && !flush_req_next))) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Choose what the output register shows next. The head is copied on entry; after a pop the entry behind it is copied.
   always_comb begin
      load_en    = !byte_valid_q || hs;
      load_valid = 1'b0;
      load_byte  = byte_q;
`ifdef SAIL_STDOUT_CRLF_EN
      if (hs && !pop) begin
         load_valid = 1'b1;
         load_byte  = LF;
      end else if (hs) begin
         load_valid = (state == ST_DRAIN) && (state_next == ST_DRAIN) && (level >= LVL_TWO);
         load_byte  = (head_after == LF) ? CR : head_after;
      end else begin
         load_valid = (state == ST_DRAIN) && (state_next == ST_DRAIN) && (level != '0);
         load_byte  = ((head == LF) && !cr_sent) ? CR : head;
      end
`else
      if (hs) begin
         load_valid = (state == ST_DRAIN) && (state_next == ST_DRAIN) && (level >= LVL_TWO);
         load_byte  = head_after;
      end else begin
         load_valid = (state == ST_DRAIN) && (state_next == ST_DRAIN) && (level != '0);
         load_byte  = head;
      end
`endif
   end

   // FIFO storage. Pointers are reset, so the contents do not need a reset.
   always_ff @(posedge in_clk) begin
      if (enq) begin
         mem[wr_ptr] <= bus.in_char;
      end
   end

   // Pointers, occupancy, newline count and flush request.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level     <= '0;
         pend_nl   <= '0;
         flush_req <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         level     <= level_next;
         pend_nl   <= pend_nl_next;
         flush_req <= flush_req_next;
      end
   end

   // State register.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered sink interface. The byte is held stable until the sink takes it.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         byte_valid_q <= 1'b0;
         byte_q       <= 8'h00;
      end else if (load_en) begin
         byte_valid_q <= load_valid;
         if (load_valid) begin
            byte_q <= load_byte;
         end
      end
   end

   // Count every byte that the sink accepts, including inserted CRs. The count wraps.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         emitted_q <= '0;
      end else if (hs) begin
         emitted_q <= emitted_q + CNT_W'(1);
      end
   end

`ifdef SAIL_STDOUT_CRLF_EN
   // Remember that the CR for the head newline has gone, so that the newline itself follows.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         cr_sent <= 1'b0;
      end else if (hs && showing_cr) begin
         cr_sent <= 1'b1;
      end else if (pop_nl) begin
         cr_sent <= 1'b0;
      end
   end
`endif

   assign bus.out_char_ready = char_ready;
   assign bus.out_byte_valid = byte_valid_q;
   assign bus.out_byte       = byte_q;
   assign bus.out_level      = level;
   assign bus.out_emitted    = emitted_q;
   assign bus.out_idle       = (state == ST_IDLE) && (level == '0);
endmodule

// File: tb/tb_sail_stdout_drain.sv
// tb_sail_stdout_drain: directed scenarios for sail_stdout_drain with DEPTH=4.
// Expected byte streams account for CR insertion when SAIL_STDOUT_CRLF_EN is defined.
module tb_sail_stdout_drain;
   localparam int DEPTH = 4;
   localparam int CNT_W = 32;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [7:0] exp_q[$];

   sail_stdout_drain_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   sail_stdout_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .in_clk   (clk),
      .in_reset (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_char_valid = 1'b0;
      bus.in_char = 8'h00;
      bus.in_flush = 1'b0;
      bus.in_byte_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_exp(input string s);
      exp_q.delete();
      for (int i = 0; i < s.len(); i++) begin
`ifdef SAIL_STDOUT_CRLF_EN
         if (s[i] == 8'h0A) exp_q.push_back(8'h0D);
`endif
         exp_q.push_back(s[i]);
      end
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         int w;
         w = 0;
         bus.in_char_valid = 1'b1;
         bus.in_char = s[i];
         while (bus.out_char_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
         end
         if (w >= 50) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got ready=%b expected 1", bus.out_char_ready);
         end
         tick();
      end
      bus.in_char_valid = 1'b0;
   endtask

   task automatic collect(input string name, input bit toggle, input int budget);
      int k;
      int cyc;
      logic held;
      logic [7:0] held_byte;
      k = 0;
      cyc = 0;
      held = 1'b0;
      held_byte = 8'h00;
      while (k < exp_q.size() && cyc < budget) begin
         bus.in_byte_ready = toggle ? (cyc % 2 == 1) : 1'b1;
         if (held) begin
            total++;
            if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== held_byte) begin
               bad++;
               $display("FAIL %s_hold: got v=%b b=%h expected v=1 b=%h", name,
                        bus.out_byte_valid, bus.out_byte, held_byte);
            end
         end
         if (bus.out_byte_valid === 1'b1 && bus.in_byte_ready) begin
            total++;
            if (bus.out_byte !== exp_q[k]) begin
               bad++;
               $display("FAIL %s_byte%0d: got %h expected %h", name, k, bus.out_byte, exp_q[k]);
            end
            k++;
            held = 1'b0;
         end else if (bus.out_byte_valid === 1'b1) begin
            held = 1'b1;
            held_byte = bus.out_byte;
         end else begin
            held = 1'b0;
         end
         tick();
         cyc++;
      end
      total++;
      if (k != exp_q.size()) begin
         bad++;
         $display("FAIL %s_timeout: got %0d bytes expected %0d", name, k, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_char_valid = 1'b0;
      bus.in_char = 8'h00;
      bus.in_flush = 1'b0;
      bus.in_byte_ready = 1'b0;
      tick();
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", bus.out_byte_valid); end
      total++; if (bus.out_byte !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h expected 00", bus.out_byte); end
      total++; if (bus.out_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d expected 0", bus.out_level); end
      total++; if (bus.out_emitted !== 32'd0) begin bad++; $display("FAIL rst_emitted: got %0d expected 0", bus.out_emitted); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b expected 1", bus.out_idle); end
      total++; if (bus.out_char_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b expected 1", bus.out_char_ready); end
      rst = 1'b0;
      tick();
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL rst_idle_after: got %b expected 1", bus.out_idle); end
   endtask

   task automatic test_line();
      do_reset();
      bus.in_byte_ready = 1'b1;
      load_exp("hi\n");
      push_str("hi\n");
      total++; if (bus.out_level !== 3'd3) begin bad++; $display("FAIL line_level: got %0d expected 3", bus.out_level); end
      tick();
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL line_early: got %b expected 0", bus.out_byte_valid); end
      tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== exp_q[i]) begin
            bad++;
            $display("FAIL line_byte%0d: got v=%b b=%h expected v=1 b=%h", i, bus.out_byte_valid, bus.out_byte, exp_q[i]);
         end
         tick();
      end
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL line_valid_end: got %b expected 0", bus.out_byte_valid); end
      total++; if (bus.out_emitted !== exp_q.size()) begin bad++; $display("FAIL line_emitted: got %0d expected %0d", bus.out_emitted, exp_q.size()); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL line_idle: got %b expected 1", bus.out_idle); end
   endtask

   task automatic test_flush();
      string s;
      s = "abc";
      do_reset();
      bus.in_byte_ready = 1'b1;
      bus.in_flush = 1'b1;
      tick();
      bus.in_flush = 1'b0;
      tick();
      tick();
      total++; if (bus.out_idle !== 1'b1 || bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got idle=%b v=%b expected idle=1 v=0", bus.out_idle, bus.out_byte_valid); end
      push_str(s);
      tick();
      tick();
      tick();
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL flush_noline_valid: got %b expected 0", bus.out_byte_valid); end
      total++; if (bus.out_level !== 3'd3) begin bad++; $display("FAIL flush_noline_level: got %0d expected 3", bus.out_level); end
      bus.in_flush = 1'b1;
      tick();
      bus.in_flush = 1'b0;
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL flush_latency: got %b expected 0", bus.out_byte_valid); end
      tick();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== s[i]) begin
            bad++;
            $display("FAIL flush_byte%0d: got v=%b b=%h expected v=1 b=%h", i, bus.out_byte_valid, bus.out_byte, s[i]);
         end
         tick();
      end
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_end: got %b expected 0", bus.out_byte_valid); end
      total++; if (bus.out_level !== 3'd0) begin bad++; $display("FAIL flush_level_end: got %0d expected 0", bus.out_level); end
      total++; if (bus.out_emitted !== 32'd3) begin bad++; $display("FAIL flush_emitted: got %0d expected 3", bus.out_emitted); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL flush_idle: got %b expected 1", bus.out_idle); end
   endtask

   task automatic test_full();
      string s;
      s = "wxyz";
      do_reset();
      bus.in_byte_ready = 1'b0;
      push_str(s);
      total++; if (bus.out_level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d expected 4", bus.out_level); end
      total++; if (bus.out_char_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b expected 0", bus.out_char_ready); end
      tick();
      tick();
      bus.in_char_valid = 1'b1;
      bus.in_char = 8'h51;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== 8'h77) begin
            bad++;
            $display("FAIL full_hold%0d: got v=%b b=%h expected v=1 b=77", i, bus.out_byte_valid, bus.out_byte);
         end
         if (i < 2) tick();
      end
      total++; if (bus.out_level !== 3'd4) begin bad++; $display("FAIL full_no_accept: got %0d expected 4", bus.out_level); end
      bus.in_char_valid = 1'b0;
      bus.in_byte_ready = 1'b1;
      #1;
      total++; if (bus.out_char_ready !== 1'b1) begin bad++; $display("FAIL full_ready_deq: got %b expected 1", bus.out_char_ready); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== s[i]) begin
            bad++;
            $display("FAIL full_byte%0d: got v=%b b=%h expected v=1 b=%h", i, bus.out_byte_valid, bus.out_byte, s[i]);
         end
         tick();
      end
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL full_valid_end: got %b expected 0", bus.out_byte_valid); end
      total++; if (bus.out_emitted !== 32'd4) begin bad++; $display("FAIL full_emitted: got %0d expected 4", bus.out_emitted); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL full_idle: got %b expected 1", bus.out_idle); end
   endtask

   task automatic test_toggle();
      do_reset();
      bus.in_byte_ready = 1'b0;
      load_exp("ok\n");
      push_str("ok\n");
      collect("toggle", 1'b1, 40);
      bus.in_byte_ready = 1'b0;
      total++; if (bus.out_emitted !== exp_q.size()) begin bad++; $display("FAIL toggle_emitted: got %0d expected %0d", bus.out_emitted, exp_q.size()); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL toggle_idle: got %b expected 1", bus.out_idle); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_byte_ready = 1'b1;
      push_str("ab\n");
      tick();
      tick();
      tick();
      total++; if (bus.out_byte_valid !== 1'b1 || bus.out_byte !== 8'h62) begin bad++; $display("FAIL mid_byte: got v=%b b=%h expected v=1 b=62", bus.out_byte_valid, bus.out_byte); end
      total++; if (bus.out_level !== 3'd2) begin bad++; $display("FAIL mid_level: got %0d expected 2", bus.out_level); end
      total++; if (bus.out_emitted !== 32'd1) begin bad++; $display("FAIL mid_emitted: got %0d expected 1", bus.out_emitted); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b expected 0", bus.out_byte_valid); end
      total++; if (bus.out_level !== 3'd0) begin bad++; $display("FAIL midrst_level: got %0d expected 0", bus.out_level); end
      total++; if (bus.out_emitted !== 32'd0) begin bad++; $display("FAIL midrst_emitted: got %0d expected 0", bus.out_emitted); end
      tick();
      tick();
      tick();
      total++; if (bus.out_byte_valid !== 1'b0 || bus.out_emitted !== 32'd0) begin bad++; $display("FAIL midrst_quiet: got v=%b n=%0d expected v=0 n=0", bus.out_byte_valid, bus.out_emitted); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL midrst_idle: got %b expected 1", bus.out_idle); end
   endtask

   task automatic test_crlf();
      do_reset();
      bus.in_byte_ready = 1'b1;
      load_exp("a\n");
      push_str("a\n");
      collect("crlf", 1'b0, 20);
      total++; if (bus.out_emitted !== exp_q.size()) begin bad++; $display("FAIL crlf_emitted: got %0d expected %0d", bus.out_emitted, exp_q.size()); end
      total++; if (bus.out_byte_valid !== 1'b0) begin bad++; $display("FAIL crlf_valid_end: got %b expected 0", bus.out_byte_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.in_byte_ready = 1'b1;
      load_exp("xy\nz\n");
      fork
         push_str("xy\nz\n");
         collect("b2b", 1'b0, 60);
      join
      total++; if (bus.out_emitted !== exp_q.size()) begin bad++; $display("FAIL b2b_emitted: got %0d expected %0d", bus.out_emitted, exp_q.size()); end
      total++; if (bus.out_idle !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b expected 1", bus.out_idle); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.in_char_valid = 1'b0;
      bus.in_char = 8'h00;
      bus.in_flush = 1'b0;
      bus.in_byte_ready = 1'b0;
      $display("[TB] sail_stdout_drain directed scenarios");
      test_reset();
      test_line();
      test_flush();
      test_full();
      test_toggle();
      test_reset_mid();
      test_crlf();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
